mest_pro_fetch_unit: RTL and testbench
======================================

# mest_pro_fetch_unit

Instruction-side responder for the MESTPro sequencing controller. It consumes the controller's one-hot state strobes (fetch/decode/execute), issues instruction-memory reads, and holds the program counter and instruction register. It decodes the opcode and returns the `exec_done` / `end_of_code` status the controller steps on. It also counts retired instructions and flags any violation of the strobe ordering.

## Interface
- `ADDR_W`, 8: instruction address width; the PC wraps modulo 2^ADDR_W.
- `INSTR_W`, 16: instruction width. Layout is `[INSTR_W-1 -: 4]` opcode and `[ADDR_W-1:0]` operand/target.
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk`  in  1  single clock; all state is on the rising edge.
- `i_reset_n`  in  1  reset; synchronous, active-low.
- `i_fetch`, `i_decode`, `i_execute`  in  1 each  controller state strobes; at most one is expected high.
- `i_zero_flag`  in  1  datapath zero flag; sampled only in the EXECUTE cycle.
- `i_pc_load`  in  1  request to load the PC from `i_pc_load_addr`.
- `i_pc_load_addr`  in  ADDR_W  PC load value.
- `o_imem_rd`  out  1  instruction memory read enable.
- `o_imem_addr`  out  ADDR_W  instruction memory address; equals the PC.
- `i_imem_rdata`  in  INSTR_W  read data from a synchronous memory, valid the cycle after `o_imem_rd`.
- `o_opcode`  out  4  IR opcode field.
- `o_operand`  out  ADDR_W  IR operand field.
- `o_exec_done`  out  1  current instruction complete.
- `o_end_of_code`  out  1  HALT is executing.
- `o_retired`  out  CNT_W  count of retired instructions.
- `o_seq_err`  out  1  sticky strobe-protocol error.

## Operation
- **Registers:** `pc`, `ir`, `retired`, `seq_err`, and `last` (the previous strobe: NONE/F/D/E).
- **Strobe tracker:** `last` follows the strobe seen each cycle. A cycle with all strobes low sets `last` to NONE.
- **FETCH cycle:** `o_imem_rd = i_fetch & i_reset_n`. `o_imem_addr = pc` at all times.
- **DECODE cycle:** `ir <= i_imem_rdata` at the end of the cycle.
- **`o_opcode` / `o_operand`:** combinational from `ir`, so they are valid throughout EXECUTE.
- **EXECUTE cycle:**
  - `o_exec_done = i_execute`. Every opcode is single-cycle.
  - `o_end_of_code = i_execute & (opcode == OP_HALT)`.
- **PC update at the end of EXECUTE:**
  - OP_HALT: `pc <= 0`.
  - OP_JMP: `pc <= operand`.
  - OP_JZ: `pc <= i_zero_flag ? operand : pc+1`.
  - All other opcodes: `pc <= pc+1`, which wraps 2^ADDR_W−1 → 0.
- **Retired counter:** `retired` increments at the end of every EXECUTE, HALT included. It saturates at all-ones.
- **PC load:** accepted only in a cycle with all three strobes low; then `pc <= i_pc_load_addr`. While any strobe is high, `i_pc_load` is ignored and raises no error.
- **Protocol errors:** `seq_err` is set when any of the following holds in a cycle:
  - more than one strobe is high; or
  - `i_decode` is high and `last != F`; or
  - `i_execute` is high and `last != D`; or
  - `i_fetch` is high and `last` is neither NONE nor E.
- **Effect of an error:**
  - On a multi-strobe cycle, no `pc`, `ir` or `retired` update occurs.
  - On a single-strobe ordering error, the normal action for that strobe still occurs.
  - `seq_err` clears only on reset.

## Timing
- **Reset values:**
  - registers: `pc=0`, `ir=0` (OP_NOP), `retired=0`, `seq_err=0`, `last=NONE`.
  - outputs: `o_imem_rd=0`, `o_imem_addr=0`, `o_opcode=0`, `o_operand=0`, `o_exec_done=0`, `o_end_of_code=0`, `o_retired=0`, `o_seq_err=0`.
- **Reset mid-instruction:** all work in progress is discarded. Reset wins over every other input in the same cycle.
- **Latency:**
  - memory address to IR capture: 2 cycles (FETCH, then DECODE).
  - IR to status outputs: 0 cycles within EXECUTE.
- **Boundary cases:**
  - JMP or JZ to the current PC is legal (tight loop).
  - HALT at address 2^ADDR_W−1 still sets `pc` to 0.
  - `i_zero_flag` outside EXECUTE is ignored.
  - `o_seq_err` rises in the cycle after the offending strobe, since it is registered.

## Structure
- **Package `mest_pro_pkg`:**
  - opcode constants `OP_NOP=4'h0`, `OP_JMP=4'h1`, `OP_JZ=4'h2`, `OP_HALT=4'hF`; all other codes are datapath ops and advance the PC;
  - the `last`-strobe enum;
  - the IR field-slicing constants.
- **Sub-module `mest_pro_seq_checker`:** the strobe tracker and `seq_err` logic, so the ordering rules can be reused on the datapath side.
- Everything else lives in one module.

## Test plan
- **Straight-line program:** memory holds `{0x3005, 0x4000, 0xF000}`; pulse start via the controller model. Required response:
  - three instruction sequences at addresses 0, 1, 2;
  - `o_end_of_code=1` only in the third EXECUTE;
  - afterwards `o_retired=3`, `pc=0`, `o_seq_err=0`.
- **Jumps:** word at address 0 is `0x2010` (JZ 0x10).
  - With `i_zero_flag=1`, the next `o_imem_addr` is 0x10.
  - With `i_zero_flag=0`, the next address is 1.
  - JMP 0x00 at 0x10 returns the PC to 0.
- **PC wrap:** load PC with 0xFF while idle, then execute a NOP. The next fetch address must be 0x00.
- **PC load gating:**
  - `i_pc_load` with address 0x40 during DECODE: ignored, and the PC continues normally.
  - The same request while idle: the next fetch is from 0x40.
- **Protocol errors:** each of these sets `o_seq_err` one cycle later and keeps it set until reset:
  - `i_fetch` and `i_decode` high together, with no `ir` or `pc` change;
  - `i_execute` directly after `i_fetch`;
  - `i_decode` after an idle cycle.
- **Reset mid-instruction:** assert `i_reset_n=0` during DECODE. On the next cycle, all outputs are at their reset values and the following fetch address is 0.

Source files
------------

// File: rtl/mest_pro_pkg.sv
// Shared definitions for the MESTPro instruction-side logic: opcodes,
// strobe-history encoding and instruction-register field layout.
package mest_pro_pkg;

  // Opcode encodings; every other code is a datapath op that simply advances the PC.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  // IR layout: opcode in the top OPCODE_W bits, operand in the low ADDR_W bits.
  localparam int OPCODE_W   = 4;
  localparam int OPERAND_LSB = 0;

  // Most recent controller strobe seen.
  typedef enum logic [1:0] {
    LAST_NONE = 2'd0,
    LAST_F    = 2'd1,
    LAST_D    = 2'd2,
    LAST_E    = 2'd3
  } last_t;

endpackage

// File: rtl/mest_pro_seq_checker.sv
// Tracks the previous controller strobe and raises a sticky error when the
// fetch -> decode -> execute ordering is broken or strobes overlap.
module mest_pro_seq_checker
  import mest_pro_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic fetch,
  input  logic decode,
  input  logic execute,
  output logic multi_strobe,
  output logic seq_err
);

  last_t last;
  logic  order_err;

  assign multi_strobe = (fetch & decode) | (fetch & execute) | (decode & execute);

  assign order_err = multi_strobe
                   | (decode  & (last != LAST_F))
                   | (execute & (last != LAST_D))
                   | (fetch   & (last != LAST_NONE) & (last != LAST_E));

  // Strobe history and sticky error flag; the error clears only on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last    <= LAST_NONE;
      seq_err <= 1'b0;
    end else begin
      // An overlapping cycle has no single meaningful strobe, so history restarts.
      if (multi_strobe)  last <= LAST_NONE;
      else if (fetch)    last <= LAST_F;
      else if (decode)   last <= LAST_D;
      else if (execute)  last <= LAST_E;
      else               last <= LAST_NONE;
      if (order_err) seq_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mest_pro_fetch_unit.sv
// Instruction-side responder: issues fetches, holds PC and IR, decodes the
// opcode for the controller and counts retired instructions.
module mest_pro_fetch_unit
  import mest_pro_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               i_reset_n,
  input  logic               i_fetch,
  input  logic               i_decode,
  input  logic               i_execute,
  input  logic               i_zero_flag,
  input  logic               i_pc_load,
  input  logic [ADDR_W-1:0]  i_pc_load_addr,
  output logic               o_imem_rd,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [3:0]         o_opcode,
  output logic [ADDR_W-1:0]  o_operand,
  output logic               o_exec_done,
  output logic               o_end_of_code,
  output logic [CNT_W-1:0]   o_retired,
  output logic               o_seq_err
);

  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   retired;
  logic               multi_strobe;
  logic               idle;
  logic [ADDR_W-1:0]  pc_next_seq;
  logic [ADDR_W-1:0]  pc_exec;

  mest_pro_seq_checker u_seq_checker (
    .clk          (clk),
    .reset_n      (i_reset_n),
    .fetch        (i_fetch),
    .decode       (i_decode),
    .execute      (i_execute),
    .multi_strobe (multi_strobe),
    .seq_err      (o_seq_err)
  );

  assign idle        = ~(i_fetch | i_decode | i_execute);
  assign pc_next_seq = pc + ADDR_W'(1);

  assign o_imem_rd     = i_fetch & i_reset_n;
  assign o_imem_addr   = pc;
  assign o_opcode      = ir[INSTR_W-1 -: OPCODE_W];
  assign o_operand     = ir[OPERAND_LSB +: ADDR_W];
  assign o_exec_done   = i_execute & i_reset_n;
  assign o_end_of_code = i_execute & i_reset_n & (o_opcode == OP_HALT);
  assign o_retired     = retired;

  // Next PC at the end of EXECUTE, chosen by the opcode held in IR.
  always_comb begin
    pc_exec = pc_next_seq;
    case (o_opcode)
      OP_HALT: pc_exec = '0;
      OP_JMP:  pc_exec = o_operand;
      OP_JZ:   pc_exec = i_zero_flag ? o_operand : pc_next_seq;
      default: pc_exec = pc_next_seq;
    endcase
  end

  // PC, IR and retired-count update; overlapping strobes freeze all three.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else if (!multi_strobe) begin
      if (i_decode) ir <= i_imem_rdata;
      if (i_execute) begin
        pc <= pc_exec;
        if (retired != '1) retired <= retired + CNT_W'(1);
      end else if (idle && i_pc_load) begin
        pc <= i_pc_load_addr;
      end
    end
  end

endmodule

// File: tb/tb_mest_pro_fetch_unit.sv
// Directed bench for mest_pro_fetch_unit: a vector table for the straight-line
// program plus hand-written sequences for jumps, wrap, PC load, errors and reset.
module tb_mest_pro_fetch_unit;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_fetch, i_decode, i_execute, i_zero_flag, i_pc_load;
  logic [7:0]  i_pc_load_addr;
  logic        o_imem_rd;
  logic [7:0]  o_imem_addr;
  logic [15:0] i_imem_rdata;
  logic [3:0]  o_opcode;
  logic [7:0]  o_operand;
  logic        o_exec_done, o_end_of_code, o_seq_err;
  logic [15:0] o_retired;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  typedef struct packed {
    logic       f, d, e, z;
    logic       exp_rd;
    logic [7:0] exp_addr;
    logic [3:0] exp_op;
    logic [7:0] exp_operand;
    logic       exp_done, exp_eoc, exp_err;
    logic [15:0] exp_ret;
  } vec_t;

  vec_t vecs [11];

  mest_pro_fetch_unit dut (
    .clk            (clk),
    .i_reset_n      (i_reset_n),
    .i_fetch        (i_fetch),
    .i_decode       (i_decode),
    .i_execute      (i_execute),
    .i_zero_flag    (i_zero_flag),
    .i_pc_load      (i_pc_load),
    .i_pc_load_addr (i_pc_load_addr),
    .o_imem_rd      (o_imem_rd),
    .o_imem_addr    (o_imem_addr),
    .i_imem_rdata   (i_imem_rdata),
    .o_opcode       (o_opcode),
    .o_operand      (o_operand),
    .o_exec_done    (o_exec_done),
    .o_end_of_code  (o_end_of_code),
    .o_retired      (o_retired),
    .o_seq_err      (o_seq_err)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the read.
  always @(posedge clk) if (o_imem_rd) i_imem_rdata <= mem[o_imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic d, input logic e, input logic z,
                       input logic pl, input logic [7:0] pla);
    i_fetch = f; i_decode = d; i_execute = e; i_zero_flag = z;
    i_pc_load = pl; i_pc_load_addr = pla;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00);
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  // One full instruction; zero flag is held high outside EXECUTE to show it is ignored there.
  task automatic run_instr(input logic z);
    drive(1, 0, 0, 1, 0, 8'h00); tick();
    drive(0, 1, 0, 1, 0, 8'h00); tick();
    drive(0, 0, 1, z, 0, 8'h00); tick();
    drive(0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    i_imem_rdata = 16'h0000;
    //          f  d  e  z  rd addr   op     opnd   dn eoc er ret
    vecs[0]  = {1'b0,1'b0,1'b0,1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0,1'b0,1'b0, 16'd0};
    vecs[1]  = {1'b1,1'b0,1'b0,1'b0, 1'b1, 8'h00, 4'h0, 8'h00, 1'b0,1'b0,1'b0, 16'd0};
    vecs[2]  = {1'b0,1'b1,1'b0,1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0,1'b0,1'b0, 16'd0};
    vecs[3]  = {1'b0,1'b0,1'b1,1'b0, 1'b0, 8'h00, 4'h3, 8'h05, 1'b1,1'b0,1'b0, 16'd0};
    vecs[4]  = {1'b1,1'b0,1'b0,1'b0, 1'b1, 8'h01, 4'h3, 8'h05, 1'b0,1'b0,1'b0, 16'd1};
    vecs[5]  = {1'b0,1'b1,1'b0,1'b0, 1'b0, 8'h01, 4'h3, 8'h05, 1'b0,1'b0,1'b0, 16'd1};
    vecs[6]  = {1'b0,1'b0,1'b1,1'b0, 1'b0, 8'h01, 4'h4, 8'h00, 1'b1,1'b0,1'b0, 16'd1};
    vecs[7]  = {1'b1,1'b0,1'b0,1'b0, 1'b1, 8'h02, 4'h4, 8'h00, 1'b0,1'b0,1'b0, 16'd2};
    vecs[8]  = {1'b0,1'b1,1'b0,1'b0, 1'b0, 8'h02, 4'h4, 8'h00, 1'b0,1'b0,1'b0, 16'd2};
    vecs[9]  = {1'b0,1'b0,1'b1,1'b0, 1'b0, 8'h02, 4'hF, 8'h00, 1'b1,1'b1,1'b0, 16'd2};
    vecs[10] = {1'b0,1'b0,1'b0,1'b0, 1'b0, 8'h00, 4'hF, 8'h00, 1'b0,1'b0,1'b0, 16'd3};

    // Reset values
    clear_mem();
    do_reset();
    check("rst_rd", o_imem_rd, 0);
    check("rst_addr", o_imem_addr, 8'h00);
    check("rst_opcode", o_opcode, 4'h0);
    check("rst_operand", o_operand, 8'h00);
    check("rst_done", o_exec_done, 0);
    check("rst_eoc", o_end_of_code, 0);
    check("rst_retired", o_retired, 16'd0);
    check("rst_seq_err", o_seq_err, 0);

    // Straight-line program from the vector table
    mem[0] = 16'h3005; mem[1] = 16'h4000; mem[2] = 16'hF000;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].f, vecs[i].d, vecs[i].e, vecs[i].z, 0, 8'h00);
      #1;
      check($sformatf("v%0d_rd", i), o_imem_rd, vecs[i].exp_rd);
      check($sformatf("v%0d_addr", i), o_imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_opcode", i), o_opcode, vecs[i].exp_op);
      check($sformatf("v%0d_operand", i), o_operand, vecs[i].exp_operand);
      check($sformatf("v%0d_done", i), o_exec_done, vecs[i].exp_done);
      check($sformatf("v%0d_eoc", i), o_end_of_code, vecs[i].exp_eoc);
      check($sformatf("v%0d_err", i), o_seq_err, vecs[i].exp_err);
      check($sformatf("v%0d_retired", i), o_retired, vecs[i].exp_ret);
      tick();
    end

    // Jumps: JZ taken, JMP back, JZ not taken
    clear_mem();
    mem[8'h00] = 16'h2010; mem[8'h10] = 16'h1000;
    do_reset();
    run_instr(1'b1);
    check("jz_taken_addr", o_imem_addr, 8'h10);
    run_instr(1'b0);
    check("jmp_back_addr", o_imem_addr, 8'h00);
    run_instr(1'b0);
    check("jz_not_taken_addr", o_imem_addr, 8'h01);
    check("jump_seq_err", o_seq_err, 0);
    check("jump_retired", o_retired, 16'd3);

    // Tight loop: JMP to its own address
    clear_mem();
    mem[8'h00] = 16'h1000;
    do_reset();
    run_instr(1'b0);
    run_instr(1'b0);
    check("tight_loop_addr", o_imem_addr, 8'h00);
    check("tight_loop_retired", o_retired, 16'd2);

    // PC wrap on a NOP at the top address
    clear_mem();
    do_reset();
    drive(0, 0, 0, 0, 1, 8'hFF); tick();
    drive(0, 0, 0, 0, 0, 8'h00);
    check("wrap_load_addr", o_imem_addr, 8'hFF);
    run_instr(1'b0);
    check("wrap_addr", o_imem_addr, 8'h00);

    // HALT at the top address returns PC to 0
    mem[8'hFF] = 16'hF0AA;
    drive(0, 0, 0, 0, 1, 8'hFF); tick();
    drive(1, 0, 0, 0, 0, 8'h00); tick();
    drive(0, 1, 0, 0, 0, 8'h00); tick();
    drive(0, 0, 1, 0, 0, 8'h00); #1;
    check("halt_top_eoc", o_end_of_code, 1);
    tick();
    drive(0, 0, 0, 0, 0, 8'h00); #1;
    check("halt_top_addr", o_imem_addr, 8'h00);
    check("halt_top_eoc_off", o_end_of_code, 0);

    // PC load gating: ignored during DECODE, accepted while idle
    clear_mem();
    do_reset();
    drive(1, 0, 0, 0, 0, 8'h00); tick();
    drive(0, 1, 0, 0, 1, 8'h40); tick();
    drive(0, 0, 1, 0, 0, 8'h00); tick();
    drive(0, 0, 0, 0, 0, 8'h00);
    check("load_decode_ignored", o_imem_addr, 8'h01);
    check("load_decode_no_err", o_seq_err, 0);
    drive(0, 0, 0, 0, 1, 8'h40); tick();
    drive(1, 0, 0, 0, 0, 8'h00); #1;
    check("load_idle_addr", o_imem_addr, 8'h40);
    check("load_idle_rd", o_imem_rd, 1);
    tick();
    drive(0, 0, 0, 0, 0, 8'h00);

    // Error: fetch and decode together freezes IR and PC
    clear_mem();
    mem[0] = 16'h3005; mem[1] = 16'h7777;
    do_reset();
    run_instr(1'b0);
    drive(1, 1, 0, 0, 0, 8'h00); #1;
    check("multi_err_not_yet", o_seq_err, 0);
    tick();
    drive(0, 1, 0, 0, 0, 8'h00); #1;
    check("multi_err_set", o_seq_err, 1);
    drive(0, 0, 0, 0, 0, 8'h00);
    tick();
    check("multi_ir_kept", o_opcode, 4'h3);
    check("multi_pc_kept", o_imem_addr, 8'h01);
    tick(); tick();
    check("multi_err_sticky", o_seq_err, 1);
    do_reset();
    check("err_cleared_by_reset", o_seq_err, 0);

    // Error: execute directly after fetch; execute still retires
    drive(1, 0, 0, 0, 0, 8'h00); tick();
    drive(0, 0, 1, 0, 0, 8'h00); tick();
    drive(0, 0, 0, 0, 0, 8'h00);
    check("fe_err_set", o_seq_err, 1);
    check("fe_retired", o_retired, 16'd1);
    check("fe_pc", o_imem_addr, 8'h01);
    tick();
    check("fe_err_sticky", o_seq_err, 1);

    // Error: decode after an idle cycle
    do_reset();
    tick();
    drive(0, 1, 0, 0, 0, 8'h00); tick();
    drive(0, 0, 0, 0, 0, 8'h00);
    check("idle_decode_err", o_seq_err, 1);

    // Reset mid-instruction
    clear_mem();
    mem[0] = 16'h3005; mem[1] = 16'h5123;
    do_reset();
    run_instr(1'b0);
    drive(1, 0, 0, 0, 0, 8'h00); tick();
    drive(0, 1, 0, 0, 0, 8'h00);
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00); #1;
    check("midrst_addr", o_imem_addr, 8'h00);
    check("midrst_opcode", o_opcode, 4'h0);
    check("midrst_operand", o_operand, 8'h00);
    check("midrst_retired", o_retired, 16'd0);
    check("midrst_err", o_seq_err, 0);
    check("midrst_done", o_exec_done, 0);
    drive(1, 0, 0, 0, 0, 8'h00); #1;
    check("midrst_fetch_addr", o_imem_addr, 8'h00);
    check("midrst_fetch_rd", o_imem_rd, 1);
    i_reset_n = 1'b0; #1;
    check("rst_gates_rd", o_imem_rd, 0);
    i_reset_n = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
